// File: rtl/bf_pkg.sv
// Shared types for the bloom-filter lookup arbiter: tuple layout and FSM states.
package bf_pkg;

  localparam int TUPLE_W = 104;

  typedef struct packed {
    logic [71:0] ip_pro;
    logic [15:0] src_port;
    logic [15:0] dest_port;
  } bf_tuple_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } bf_arb_state_e;

endpackage

// File: rtl/bf_lookup_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module bf_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [PTR_W-1:0] o_gnt_idx,
  output logic             o_any
);

  int                 w_sum;
  logic [PTR_W-1:0]   w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_sum     = 0;
    w_idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = int'(i_ptr) + i;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_idx = PTR_W'(w_sum);
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/bf_lookup_arbiter.sv
// Shares one bloom filter among NREQ requesters, one lookup in flight, with timeout.
// Optional statistics counters are enabled by defining BF_ARB_STATS_EN.
module bf_lookup_arbiter
  import bf_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
`ifdef BF_ARB_STATS_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*TUPLE_W-1:0] req_tuple,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic                    rsp_hit,
  output logic                    rsp_err,
  output logic                    bf_valid,
  output logic [71:0]             bf_ip_pro,
  output logic [15:0]             bf_src_port,
  output logic [15:0]             bf_dest_port,
  input  logic                    bf_readyRecv,
  input  logic                    bf_readyRes,
  input  logic                    bf_get_Result,
`ifdef BF_ARB_STATS_EN
  input  logic                    stat_clr,
  output logic [CNT_W-1:0]        stat_lookups,
  output logic [CNT_W-1:0]        stat_hits,
  output logic [CNT_W-1:0]        stat_timeouts,
`endif
  output logic                    busy
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int TMR_W = $clog2(TIMEOUT);

  bf_arb_state_e      r_state, w_next;
  logic [PTR_W-1:0]   r_ptr, r_gnt_idx, w_gnt_idx;
  logic [NREQ-1:0]    w_gnt;
  logic               w_any;
  bf_tuple_t          r_tuple, w_sel_tuple;
  logic [TMR_W-1:0]   r_timer;
  logic               r_hit, r_err;
  logic               w_rsp_accept, w_expired;

  bf_rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_sel_tuple  = req_tuple[int'(w_gnt_idx)*TUPLE_W +: TUPLE_W];
  assign w_rsp_accept = (r_state == RESP) && rsp_ready[r_gnt_idx];
  assign w_expired    = (r_timer == TMR_W'(TIMEOUT - 1));

  assign bf_ip_pro    = r_tuple.ip_pro;
  assign bf_src_port  = r_tuple.src_port;
  assign bf_dest_port = r_tuple.dest_port;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    rsp_hit   = 1'b0;
    rsp_err   = 1'b0;
    bf_valid  = 1'b0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        req_ready = w_gnt;
        if (w_any) w_next = ISSUE;
      end
      ISSUE: begin
        bf_valid = 1'b1;
        if (bf_readyRecv) w_next = WAIT;
      end
      // A result arriving on the expiry cycle still counts as a normal response.
      WAIT: begin
        if (bf_readyRes || w_expired) w_next = RESP;
      end
      RESP: begin
        rsp_valid[r_gnt_idx] = 1'b1;
        rsp_hit              = r_hit;
        rsp_err              = r_err;
        if (w_rsp_accept) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_gnt_idx <= '0;
      r_tuple   <= '0;
      r_timer   <= '0;
      r_hit     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_tuple   <= w_sel_tuple;
          r_gnt_idx <= w_gnt_idx;
          r_hit     <= 1'b0;
          r_err     <= 1'b0;
        end
        ISSUE: if (bf_readyRecv) r_timer <= '0;
        WAIT: begin
          if (bf_readyRes) begin
            r_hit <= bf_get_Result;
            r_err <= 1'b0;
          end else if (w_expired) begin
            r_hit <= 1'b0;
            r_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RESP: if (w_rsp_accept) begin
          r_ptr <= (r_gnt_idx == PTR_W'(NREQ - 1)) ? '0 : r_gnt_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BF_ARB_STATS_EN
  // Counters saturate at all-ones; a clear beats an increment in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_lookups  <= '0;
      stat_hits     <= '0;
      stat_timeouts <= '0;
    end else if (stat_clr) begin
      stat_lookups  <= '0;
      stat_hits     <= '0;
      stat_timeouts <= '0;
    end else if (w_rsp_accept) begin
      if (stat_lookups != '1)            stat_lookups  <= stat_lookups + 1'b1;
      if (r_hit && (stat_hits != '1))     stat_hits     <= stat_hits + 1'b1;
      if (r_err && (stat_timeouts != '1)) stat_timeouts <= stat_timeouts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bf_lookup_arbiter.sv
// Self-checking bench for bf_lookup_arbiter; the bench plays the bloom filter.
module tb_bf_lookup_arbiter;
  import bf_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic                    clk;
  logic                    reset;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*TUPLE_W-1:0] req_tuple;
  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready;
  logic                    rsp_hit;
  logic                    rsp_err;
  logic                    bf_valid;
  logic [71:0]             bf_ip_pro;
  logic [15:0]             bf_src_port;
  logic [15:0]             bf_dest_port;
  logic                    bf_readyRecv;
  logic                    bf_readyRes;
  logic                    bf_get_Result;
  logic                    busy;
`ifdef BF_ARB_STATS_EN
  logic                    stat_clr;
  logic [31:0]             stat_lookups, stat_hits, stat_timeouts;
  int                      expLookups = 0, expHits = 0, expTimeouts = 0;
  bit                      clrAtAccept = 1'b0;
`endif

  int        checks = 0;
  int        errors = 0;
  int        refPtr = 0;
  bf_tuple_t slotTuple[NREQ];

  typedef struct {
    logic [3:0] valids;
    int         recvDelay;
    int         resDelay;
    bit         resBit;
    int         rspDelay;
    int         expGnt;
    bit         expHit;
    bit         expErr;
  } vector_t;

  vector_t vecs[10];

  bf_lookup_arbiter #(
    .NREQ(NREQ),
    .TIMEOUT(TIMEOUT)
`ifdef BF_ARB_STATS_EN
    ,
    .CNT_W(32)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_tuple     (req_tuple),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_hit       (rsp_hit),
    .rsp_err       (rsp_err),
    .bf_valid      (bf_valid),
    .bf_ip_pro     (bf_ip_pro),
    .bf_src_port   (bf_src_port),
    .bf_dest_port  (bf_dest_port),
    .bf_readyRecv  (bf_readyRecv),
    .bf_readyRes   (bf_readyRes),
    .bf_get_Result (bf_get_Result),
`ifdef BF_ARB_STATS_EN
    .stat_clr      (stat_clr),
    .stat_lookups  (stat_lookups),
    .stat_hits     (stat_hits),
    .stat_timeouts (stat_timeouts),
`endif
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int modelPick(input logic [3:0] valids, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (valids[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return 0;
  endfunction

  function automatic bf_tuple_t randTuple();
    bf_tuple_t t;
    t.ip_pro    = {$urandom, $urandom, 8'($urandom)};
    t.src_port  = 16'($urandom);
    t.dest_port = 16'($urandom);
    return t;
  endfunction

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_flags"}, {rsp_hit, rsp_err}, 0);
    checkOutput({tag, "_bf_valid"}, bf_valid, 0);
    checkOutput({tag, "_bf_tuple"}, {bf_ip_pro, bf_src_port, bf_dest_port}, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  // Entered and left at a falling edge with the DUT idle.
  task automatic applyStimulus(input logic [3:0] valids, input int recvDelay, input int resDelay,
                               input bit resBit, input int rspDelay, input int expGnt,
                               input bit expHit, input bit expErr);
    logic [3:0] oneHot;
    int         waitCycles;
    oneHot = 4'b0001 << expGnt;
    for (int i = 0; i < NREQ; i++) req_tuple[i*TUPLE_W +: TUPLE_W] = slotTuple[i];
    req_valid     = valids;
    rsp_ready     = '0;
    bf_readyRecv  = 1'b0;
    bf_readyRes   = 1'b0;
    bf_get_Result = 1'b0;
    #1;
    checkOutput("idle_busy", busy, 0);
    checkOutput("grant", req_ready, oneHot);
    @(negedge clk);
    req_valid = '0;
    for (int d = 0; d <= recvDelay; d++) begin
      bf_readyRecv  = (d == recvDelay);
      bf_readyRes   = 1'($urandom_range(0, 1));
      bf_get_Result = 1'($urandom_range(0, 1));
      #1;
      checkOutput("issue_bf_valid", bf_valid, 1);
      checkOutput("issue_tuple", {bf_ip_pro, bf_src_port, bf_dest_port}, slotTuple[expGnt]);
      checkOutput("issue_req_ready", req_ready, 0);
      @(negedge clk);
    end
    waitCycles = (resDelay < TIMEOUT) ? resDelay + 1 : TIMEOUT;
    for (int k = 0; k < waitCycles; k++) begin
      bf_readyRecv  = 1'b0;
      bf_readyRes   = (k == resDelay);
      bf_get_Result = (k == resDelay) ? resBit : 1'($urandom_range(0, 1));
      #1;
      checkOutput("wait_bf_valid", bf_valid, 0);
      checkOutput("wait_rsp_valid", rsp_valid, 0);
      checkOutput("wait_busy", busy, 1);
      @(negedge clk);
    end
    bf_readyRes   = 1'b0;
    bf_get_Result = 1'b0;
    for (int r = 0; r <= rspDelay; r++) begin
      rsp_ready = (r == rspDelay) ? oneHot : ~oneHot;
      req_valid = (r == rspDelay) ? 4'hF : 4'h0;
`ifdef BF_ARB_STATS_EN
      stat_clr  = (r == rspDelay) && clrAtAccept;
`endif
      #1;
      checkOutput("rsp_valid", rsp_valid, oneHot);
      checkOutput("rsp_hit", rsp_hit, expHit);
      checkOutput("rsp_err", rsp_err, expErr);
      checkOutput("rsp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = '0;
`ifdef BF_ARB_STATS_EN
    stat_clr = 1'b0;
    if (clrAtAccept) begin
      expLookups = 0; expHits = 0; expTimeouts = 0;
    end else begin
      expLookups++;
      if (expHit) expHits++;
      if (expErr) expTimeouts++;
    end
`endif
    refPtr = (expGnt + 1) % NREQ;
  endtask

  initial begin
    bf_tuple_t  t1;
    logic [3:0] rv;
    int         rd, rs, rp, g;
    bit         rb, eErr;

    vecs[0] = '{4'hF, 0, 0,   1'b1, 0, 0, 1'b1, 1'b0};
    vecs[1] = '{4'hF, 1, 1,   1'b0, 1, 1, 1'b0, 1'b0};
    vecs[2] = '{4'hF, 0, 2,   1'b1, 0, 2, 1'b1, 1'b0};
    vecs[3] = '{4'hF, 2, 0,   1'b0, 2, 3, 1'b0, 1'b0};
    vecs[4] = '{4'hF, 0, 0,   1'b1, 0, 0, 1'b1, 1'b0};
    vecs[5] = '{4'h1, 0, 2,   1'b1, 0, 0, 1'b1, 1'b0};
    vecs[6] = '{4'h4, 1, 100, 1'b1, 1, 2, 1'b0, 1'b1};
    vecs[7] = '{4'hA, 0, 7,   1'b1, 0, 3, 1'b1, 1'b0};
    vecs[8] = '{4'hA, 0, 8,   1'b1, 0, 1, 1'b0, 1'b1};
    vecs[9] = '{4'h3, 3, 0,   1'b0, 0, 0, 1'b0, 1'b0};

    t1.ip_pro    = {8'd192, 8'd169, 8'd1, 8'd30, 8'd192, 8'd168, 8'd1, 8'd30, 8'd30};
    t1.src_port  = 16'd16538;
    t1.dest_port = 16'd37281;

    reset = 1'b0; req_valid = '0; req_tuple = '0; rsp_ready = '0;
    bf_readyRecv = 1'b0; bf_readyRes = 1'b0; bf_get_Result = 1'b0;
`ifdef BF_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    checkAllIdle("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < NREQ; i++) slotTuple[i] = randTuple();
      if (v == 5) slotTuple[0] = t1;
      applyStimulus(vecs[v].valids, vecs[v].recvDelay, vecs[v].resDelay, vecs[v].resBit,
                    vecs[v].rspDelay, vecs[v].expGnt, vecs[v].expHit, vecs[v].expErr);
    end

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NREQ; i++) slotTuple[i] = randTuple();
      rv   = 4'($urandom_range(1, 15));
      rd   = $urandom_range(0, 3);
      rs   = $urandom_range(0, 11);
      rb   = 1'($urandom_range(0, 1));
      rp   = $urandom_range(0, 2);
      g    = modelPick(rv, refPtr);
      eErr = (rs >= TIMEOUT);
      applyStimulus(rv, rd, rs, rb, rp, g, rb && !eErr, eErr);
    end

`ifdef BF_ARB_STATS_EN
    checkOutput("stat_lookups", stat_lookups, expLookups);
    checkOutput("stat_hits", stat_hits, expHits);
    checkOutput("stat_timeouts", stat_timeouts, expTimeouts);
    clrAtAccept = 1'b1;
    applyStimulus(4'h1, 0, 0, 1'b1, 0, 0, 1'b1, 1'b0);
    clrAtAccept = 1'b0;
    #1;
    checkOutput("stat_clr_lookups", stat_lookups, 0);
    checkOutput("stat_clr_hits", stat_hits, 0);
    checkOutput("stat_clr_timeouts", stat_timeouts, 0);
`endif

    // Reset in the middle of WAIT drops the lookup silently.
    req_valid = 4'h8;
    #1;
    checkOutput("t5_grant", req_ready, 4'b0001 << modelPick(4'h8, refPtr));
    @(negedge clk);
    req_valid = '0; bf_readyRecv = 1'b1;
    @(negedge clk);
    bf_readyRecv = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("t5_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    checkAllIdle("t5_reset");
    @(negedge clk);
    reset = 1'b1;
    refPtr = 0;
`ifdef BF_ARB_STATS_EN
    expLookups = 0; expHits = 0; expTimeouts = 0;
`endif
    bf_readyRes = 1'b1; bf_get_Result = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      checkAllIdle("t5_after");
    end
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) slotTuple[i] = randTuple();
    applyStimulus(4'hF, 0, 1, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < NREQ; i++) slotTuple[i] = randTuple();
    applyStimulus(4'hF, 0, 0, 1'b1, 0, 1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
